// File: rtl/pid_pkg.sv
// Shared widths, output range and datapath types for the PID combine stage.
package pid_pkg;
    localparam int P_W   = 14;
    localparam int I_W   = 12;
    localparam int D_W   = 13;
    localparam int OUT_W = 12;
    localparam int SUM_W = 15;

    typedef logic signed [SUM_W-1:0] pid_sum_t;
    typedef logic signed [OUT_W-1:0] drv_t;

    localparam drv_t OUT_MAX = drv_t'((1 << (OUT_W-1)) - 1);
    localparam drv_t OUT_MIN = drv_t'(-(1 << (OUT_W-1)));
endpackage

// File: rtl/sat_signed.sv
// Combinational signed clip from IN_W to OUT_W bits with clip-high / clip-low flags.
module sat_signed #(
    parameter int IN_W  = 15,
    parameter int OUT_W = 12
) (
    input  logic signed [IN_W-1:0]  din,
    output logic signed [OUT_W-1:0] dout,
    output logic                    hi,
    output logic                    lo
);
    localparam logic signed [IN_W-1:0] MAXV = IN_W'((1 << (OUT_W-1)) - 1);
    localparam logic signed [IN_W-1:0] MINV = IN_W'(-(1 << (OUT_W-1)));

    always_comb begin
        hi   = (din > MAXV);
        lo   = (din < MINV);
        dout = din[OUT_W-1:0];
        if (hi) begin
            dout = MAXV[OUT_W-1:0];
        end else if (lo) begin
            dout = MINV[OUT_W-1:0];
        end
    end
endmodule

// File: rtl/pid_combine.sv
// Sums P/I/D terms, clips to the drive width and tracks consecutive saturation.
// Optional output slew limiting is enabled by defining SLEW_LIMIT_EN.
module pid_combine
    import pid_pkg::*;
#(
    parameter logic [7:0] SAT_LIMIT = 8'd64,
    parameter int         SLEW_STEP = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  vld,
    input  logic signed [P_W-1:0] P_term,
    input  logic signed [I_W-1:0] I_term,
    input  logic signed [D_W-1:0] D_term,
    input  logic                  clr_fault,
    output drv_t                  pid_out,
    output logic                  pid_vld,
    output logic                  sat_hi,
    output logic                  sat_lo,
    output logic [7:0]            sat_cnt,
    output logic                  sat_fault
);
    pid_sum_t   p_reg, i_reg, d_reg, sum_reg;
    logic       s1_vld_reg, s2_vld_reg;
    drv_t       clip;
    logic       clip_hi, clip_lo;
    drv_t       out_next;
    drv_t       pid_out_reg;
    logic       pid_vld_reg, sat_hi_reg, sat_lo_reg;
    logic [7:0] sat_cnt_reg, sat_cnt_next;
    logic       sat_fault_reg, sat_fault_next;

    // S1: capture sign-extended terms; S2: 15-bit sum cannot overflow
    always_ff @(posedge clk) begin
        if (rst) begin
            p_reg      <= '0;
            i_reg      <= '0;
            d_reg      <= '0;
            sum_reg    <= '0;
            s1_vld_reg <= 1'b0;
            s2_vld_reg <= 1'b0;
        end else begin
            if (vld) begin
                p_reg <= pid_sum_t'(P_term);
                i_reg <= pid_sum_t'(I_term);
                d_reg <= pid_sum_t'(D_term);
            end
            s1_vld_reg <= vld;
            if (s1_vld_reg) begin
                sum_reg <= p_reg + i_reg + d_reg;
            end
            s2_vld_reg <= s1_vld_reg;
        end
    end

    sat_signed #(
        .IN_W  (SUM_W),
        .OUT_W (OUT_W)
    ) u_sat (
        .din  (sum_reg),
        .dout (clip),
        .hi   (clip_hi),
        .lo   (clip_lo)
    );

`ifdef SLEW_LIMIT_EN
    localparam int DW = OUT_W + 1;
    localparam logic signed [DW-1:0] STEP_P = DW'(SLEW_STEP);
    localparam logic signed [DW-1:0] STEP_N = DW'(-SLEW_STEP);
    logic signed [DW-1:0] diff, step, slewed;

    // Move from the previous command toward the clipped target by at most SLEW_STEP
    always_comb begin
        diff = DW'(clip) - DW'(pid_out_reg);
        step = diff;
        if (diff > STEP_P) begin
            step = STEP_P;
        end else if (diff < STEP_N) begin
            step = STEP_N;
        end
        slewed   = DW'(pid_out_reg) + step;
        out_next = slewed[OUT_W-1:0];
    end
`else
    assign out_next = clip;
`endif

    // Clear request overrides a saturated sample landing in the same cycle
    always_comb begin
        sat_cnt_next   = sat_cnt_reg;
        sat_fault_next = sat_fault_reg;
        if (s2_vld_reg) begin
            if (clip_hi || clip_lo) begin
                sat_cnt_next = (sat_cnt_reg == 8'hFF) ? 8'hFF : sat_cnt_reg + 8'd1;
            end else begin
                sat_cnt_next = 8'd0;
            end
            if (sat_cnt_next >= SAT_LIMIT) begin
                sat_fault_next = 1'b1;
            end
        end
        if (clr_fault) begin
            sat_cnt_next   = 8'd0;
            sat_fault_next = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pid_out_reg   <= '0;
            pid_vld_reg   <= 1'b0;
            sat_hi_reg    <= 1'b0;
            sat_lo_reg    <= 1'b0;
            sat_cnt_reg   <= 8'd0;
            sat_fault_reg <= 1'b0;
        end else begin
            pid_vld_reg <= s2_vld_reg;
            if (s2_vld_reg) begin
                pid_out_reg <= out_next;
                sat_hi_reg  <= clip_hi;
                sat_lo_reg  <= clip_lo;
            end
            sat_cnt_reg   <= sat_cnt_next;
            sat_fault_reg <= sat_fault_next;
        end
    end

    assign pid_out   = pid_out_reg;
    assign pid_vld   = pid_vld_reg;
    assign sat_hi    = sat_hi_reg;
    assign sat_lo    = sat_lo_reg;
    assign sat_cnt   = sat_cnt_reg;
    assign sat_fault = sat_fault_reg;
endmodule

// File: tb/tb_pid_combine.sv
// Directed bench for pid_combine with SAT_LIMIT=4; honours SLEW_LIMIT_EN when defined.
module tb_pid_combine;
    import pid_pkg::*;

    logic                  clk = 1'b0;
    logic                  rst = 1'b1;
    logic                  vld = 1'b0;
    logic signed [P_W-1:0] P_term = '0;
    logic signed [I_W-1:0] I_term = '0;
    logic signed [D_W-1:0] D_term = '0;
    logic                  clr_fault = 1'b0;
    drv_t                  pid_out;
    logic                  pid_vld, sat_hi, sat_lo, sat_fault;
    logic [7:0]            sat_cnt;

    int checks = 0;
    int errors = 0;
    int model_prev = 0;

    pid_combine #(
        .SAT_LIMIT (8'd4),
        .SLEW_STEP (16)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .vld       (vld),
        .P_term    (P_term),
        .I_term    (I_term),
        .D_term    (D_term),
        .clr_fault (clr_fault),
        .pid_out   (pid_out),
        .pid_vld   (pid_vld),
        .sat_hi    (sat_hi),
        .sat_lo    (sat_lo),
        .sat_cnt   (sat_cnt),
        .sat_fault (sat_fault)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic signed [31:0] obs,
                         input logic signed [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Expected command for a clipped target, following the slew rule when enabled
    function automatic int model(input int clip_val);
`ifdef SLEW_LIMIT_EN
        int d;
        d = clip_val - model_prev;
        if (d > 16) d = 16;
        if (d < -16) d = -16;
        model_prev = model_prev + d;
        return model_prev;
`else
        return clip_val;
`endif
    endfunction

    task automatic drive(input int p, input int i, input int d);
        vld    = 1'b1;
        P_term = P_W'(p);
        I_term = I_W'(i);
        D_term = D_W'(d);
    endtask

    // One sample in, then wait until its S3 result is registered
    task automatic send(input int p, input int i, input int d);
        drive(p, i, d);
        tick();
        vld = 1'b0;
        tick();
        tick();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        model_prev = 0;
    endtask

    int tp [10] = '{0, 1, -10, 500, 1000, 1500, -1000, -7, 300, 2000};
    int ti [10] = '{0, 2, 5, 100, 1000, 600, -1000, 0, -300, 47};
    int td [10] = '{0, 3, 1, -50, -1, 0, -50, 0, 12, 0};
    int te [10] = '{0, 6, -4, 550, 1999, 2047, -2048, -7, 12, 2047};
    int th [10] = '{0, 0, 0, 0, 0, 1, 0, 0, 0, 0};
    int tl [10] = '{0, 0, 0, 0, 0, 0, 1, 0, 0, 0};

    initial begin
        tick();
        tick();
        rst = 1'b0;
        model_prev = 0;
        check("reset_out", pid_out, 0);
        check("reset_vld", pid_vld, 0);
        check("reset_hi", sat_hi, 0);
        check("reset_lo", sat_lo, 0);
        check("reset_cnt", sat_cnt, 0);
        check("reset_fault", sat_fault, 0);

        // Basic sum and 3-cycle latency
        drive(100, 20, -5);
        tick();
        vld = 1'b0;
        tick();
        check("lat_early", pid_vld, 0);
        tick();
        check("t1_vld", pid_vld, 1);
        check("t1_out", pid_out, model(115));
        check("t1_hi", sat_hi, 0);
        check("t1_lo", sat_lo, 0);
        tick();
        check("t1_pulse_end", pid_vld, 0);
        check("t1_hold", pid_out, model_prev == 0 ? 115 : model_prev);

        // Extreme clipping both ways
        send(8191, 2047, 4095);
        check("t2_hi_out", pid_out, model(2047));
        check("t2_hi", sat_hi, 1);
        check("t2_hi_lo", sat_lo, 0);
        send(-8192, -2048, -4096);
        check("t2_lo_out", pid_out, model(-2048));
        check("t2_lo", sat_lo, 1);
        check("t2_lo_hi", sat_hi, 0);

        // Back-to-back stream
        do_reset();
        for (int c = 0; c < 12; c++) begin
            if (c < 10) drive(tp[c], ti[c], td[c]);
            else vld = 1'b0;
            tick();
            if (c >= 2) begin
                check($sformatf("t3_vld%0d", c - 2), pid_vld, 1);
                check($sformatf("t3_out%0d", c - 2), pid_out, model(te[c - 2]));
                check($sformatf("t3_hi%0d", c - 2), sat_hi, th[c - 2]);
                check($sformatf("t3_lo%0d", c - 2), sat_lo, tl[c - 2]);
            end
        end
        vld = 1'b0;
        tick();
        check("t3_stop", pid_vld, 0);

        // Saturation counter and fault
        do_reset();
        for (int k = 1; k <= 4; k++) begin
            send(8191, 2047, 4095);
            check($sformatf("t4_cnt%0d", k), sat_cnt, k);
            check($sformatf("t4_fault%0d", k), sat_fault, (k >= 4) ? 1 : 0);
        end
        send(100, 0, 0);
        check("t4_inrange_cnt", sat_cnt, 0);
        check("t4_inrange_fault", sat_fault, 1);
        clr_fault = 1'b1;
        tick();
        clr_fault = 1'b0;
        check("t4_clr_fault", sat_fault, 0);
        check("t4_clr_cnt", sat_cnt, 0);
        send(-8192, -2048, -4096);
        check("t4_cnt_again", sat_cnt, 1);
        drive(-8192, -2048, -4096);
        tick();
        vld = 1'b0;
        tick();
        clr_fault = 1'b1;
        tick();
        clr_fault = 1'b0;
        check("t4_clrwin_vld", pid_vld, 1);
        check("t4_clrwin_cnt", sat_cnt, 0);
        check("t4_clrwin_fault", sat_fault, 0);

        // Reset with two samples in flight
        drive(8191, 2047, 4095);
        tick();
        drive(300, 0, 0);
        tick();
        vld = 1'b0;
        do_reset();
        for (int k = 0; k < 5; k++) begin
            check($sformatf("t5_novld%0d", k), pid_vld, 0);
            tick();
        end
        check("t5_out", pid_out, 0);
        check("t5_hi", sat_hi, 0);
        check("t5_lo", sat_lo, 0);
        check("t5_cnt", sat_cnt, 0);
        check("t5_fault", sat_fault, 0);

        // Repeated target 2047 from reset
        for (int n = 0; n < 4; n++) begin
            send(2047, 0, 0);
`ifdef SLEW_LIMIT_EN
            check($sformatf("t6_out%0d", n), pid_out, 16 * (n + 1));
`else
            check($sformatf("t6_out%0d", n), pid_out, 2047);
`endif
            check($sformatf("t6_hi%0d", n), sat_hi, 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
